pokey_bus_arbiter: RTL and testbench

POKEY_BUS_ARBITER -- requirements
Module: pokey_bus_arbiter

---
 rtl/pokey_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_pokey_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pokey_bus_arbiter.sv
// Shares one POKEY register bus between a host port and a write-only player FIFO.
// Define POKEY_ARB_STARVE_EN to give the FIFO one slot after three host grants made while it waits.
module pokey_bus_arbiter #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          h_req,
  input  logic                          h_rw,
  input  logic [3:0]                    h_addr,
  input  logic [7:0]                    h_wdata,
  output logic                          h_gnt,
  output logic                          h_done,
  output logic [7:0]                    h_rdata,
  input  logic                          p_valid,
  input  logic [3:0]                    p_addr,
  input  logic [7:0]                    p_data,
  output logic                          p_ready,
  output logic [1:0]                    pk_cs,
  output logic                          pk_rw,
  output logic [3:0]                    pk_a,
  output logic [7:0]                    pk_dout,
  input  logic [7:0]                    pk_din,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_own_host;
  logic            r_rw;
  logic [3:0]      r_addr;
  logic [7:0]      r_data;
  logic            r_h_gnt;
  logic            r_h_done;
  logic [7:0]      r_h_rdata;
  logic [1:0]      r_pk_cs;
  logic            r_pk_rw;
  logic [3:0]      r_pk_a;
  logic [7:0]      r_pk_dout;
  logic            r_busy;

  logic [11:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_p_ready;

  logic            w_grant_host;
  logic            w_grant_player;
  logic            w_host_ok;
  logic            w_done;
  logic            w_pop;
  logic            w_push;
  logic            w_fifo_nempty;
  logic [11:0]     w_head;
  logic [LW-1:0]   w_level_nxt;
  logic            w_own_host_nxt;
  logic            w_rw_nxt;
  logic [3:0]      w_addr_nxt;
  logic [7:0]      w_data_nxt;
  logic            w_active_nxt;
  logic [7:0]      w_rdata_nxt;

  assign w_fifo_nempty = (r_level != {LW{1'b0}});
  assign w_head        = r_mem[r_rptr];
  assign w_push        = p_valid & r_p_ready;

`ifdef POKEY_ARB_STARVE_EN
  logic [1:0] r_starve;

  assign w_host_ok = h_req & ~((r_starve == 2'd3) & w_fifo_nempty);

  // Counts host wins while the FIFO is waiting; never exceeds 3 because 3 forces a player grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= 2'd0;
    end else if (w_grant_host && w_fifo_nempty) begin
      r_starve <= r_starve + 2'd1;
    end else if (w_grant_player || (en && !w_fifo_nempty)) begin
      r_starve <= 2'd0;
    end else begin
      r_starve <= r_starve;
    end
  end
`else
  assign w_host_ok = h_req;
`endif

  // Arbitration and state sequencing; nothing advances without an en strobe.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_host   = 1'b0;
    w_grant_player = 1'b0;
    w_done         = 1'b0;
    w_pop          = 1'b0;
    if (en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_host_ok) begin
            w_grant_host = 1'b1;
            w_state_nxt  = ST_ADDR;
          end else if (w_fifo_nempty) begin
            w_grant_player = 1'b1;
            w_state_nxt    = ST_ADDR;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ADDR:   w_state_nxt = ST_ACCESS;
        ST_ACCESS: begin
          w_state_nxt = ST_IDLE;
          if (r_own_host) begin
            w_done = 1'b1;
          end else begin
            w_pop = 1'b1;
          end
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Next values for the latched request and for the registered bus/host outputs.
  always_comb begin
    w_own_host_nxt = r_own_host;
    w_rw_nxt       = r_rw;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    if (w_grant_host) begin
      w_own_host_nxt = 1'b1;
      w_rw_nxt       = h_rw;
      w_addr_nxt     = h_addr;
      w_data_nxt     = h_wdata;
    end else if (w_grant_player) begin
      w_own_host_nxt = 1'b0;
      w_rw_nxt       = 1'b0;
      w_addr_nxt     = w_head[11:8];
      w_data_nxt     = w_head[7:0];
    end else begin
      w_own_host_nxt = r_own_host;
    end
    w_active_nxt = (w_state_nxt != ST_IDLE);
    if (w_done && r_rw) begin
      w_rdata_nxt = pk_din;
    end else begin
      w_rdata_nxt = r_h_rdata;
    end
  end

  // Control and output registers; reset mid-access drops the cycle silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_own_host <= 1'b0;
      r_rw       <= 1'b1;
      r_addr     <= 4'h0;
      r_data     <= 8'h00;
      r_h_gnt    <= 1'b0;
      r_h_done   <= 1'b0;
      r_h_rdata  <= 8'h00;
      r_pk_cs    <= 2'b10;
      r_pk_rw    <= 1'b1;
      r_pk_a     <= 4'h0;
      r_pk_dout  <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_own_host <= w_own_host_nxt;
      r_rw       <= w_rw_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_h_gnt    <= w_active_nxt & w_own_host_nxt;
      r_h_done   <= w_done;
      r_h_rdata  <= w_rdata_nxt;
      r_pk_cs    <= (w_state_nxt == ST_ACCESS) ? 2'b01 : 2'b10;
      r_pk_rw    <= w_active_nxt ? w_rw_nxt : 1'b1;
      r_pk_a     <= w_active_nxt ? w_addr_nxt : 4'h0;
      r_pk_dout  <= w_active_nxt ? w_data_nxt : 8'h00;
      r_busy     <= w_active_nxt;
    end
  end

  // A push while full is refused even if the same clock pops.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // FIFO pointers and occupancy; pushes proceed regardless of en.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= {AW{1'b0}};
      r_rptr    <= {AW{1'b0}};
      r_level   <= {LW{1'b0}};
      r_p_ready <= 1'b1;
    end else begin
      r_wptr    <= w_push ? (r_wptr + PTR_ONE) : r_wptr;
      r_rptr    <= w_pop ? (r_rptr + PTR_ONE) : r_rptr;
      r_level   <= w_level_nxt;
      r_p_ready <= (w_level_nxt < DEPTH_L);
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {p_addr, p_data};
    end
  end

  assign h_gnt      = r_h_gnt;
  assign h_done     = r_h_done;
  assign h_rdata    = r_h_rdata;
  assign p_ready    = r_p_ready;
  assign pk_cs      = r_pk_cs;
  assign pk_rw      = r_pk_rw;
  assign pk_a       = r_pk_a;
  assign pk_dout    = r_pk_dout;
  assign fifo_level = r_level;
  assign busy       = r_busy;

endmodule

// File: tb/tb_pokey_bus_arbiter.sv
// Directed bench for pokey_bus_arbiter: transaction-level model compared every cycle plus literal checks.
module tb_pokey_bus_arbiter;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset, en, h_req, h_rw, p_valid;
  logic [3:0] h_addr, p_addr;
  logic [7:0] h_wdata, p_data, pk_din;
  logic h_gnt, h_done, p_ready, pk_rw, busy;
  logic [7:0] h_rdata, pk_dout;
  logic [1:0] pk_cs;
  logic [3:0] pk_a;
  logic [LW-1:0] fifo_level;

  pokey_bus_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en),
    .h_req(h_req), .h_rw(h_rw), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_done(h_done), .h_rdata(h_rdata),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_ready(p_ready),
    .pk_cs(pk_cs), .pk_rw(pk_rw), .pk_a(pk_a), .pk_dout(pk_dout), .pk_din(pk_din),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access is a count of en strobes consumed (0 = idle); the FIFO is a queue.
  int          m_phase = 0;
  bit          m_host = 1'b0, m_rw = 1'b1, m_done = 1'b0, m_live = 1'b0;
  logic [3:0]  m_a = 4'h0;
  logic [7:0]  m_d = 8'h00, m_rdata = 8'h00;
  int          m_starve = 0;
  logic [11:0] m_q[$];
  bit          m_push, m_pop, m_host_ok;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_host = 1'b0; m_rw = 1'b1; m_a = 4'h0; m_d = 8'h00;
      m_done = 1'b0; m_rdata = 8'h00; m_starve = 0; m_q.delete(); m_live = 1'b1;
    end else begin
      m_push = p_valid && (m_q.size() < DEPTH);
      m_pop = 1'b0;
      m_done = 1'b0;
      if (en) begin
        if (m_phase == 0) begin
          m_host_ok = h_req;
`ifdef POKEY_ARB_STARVE_EN
          if (m_starve >= 3 && m_q.size() > 0) m_host_ok = 1'b0;
`endif
          if (m_host_ok) begin
            m_host = 1'b1; m_rw = h_rw; m_a = h_addr; m_d = h_wdata; m_phase = 1;
            if (m_q.size() > 0) m_starve++;
          end else if (m_q.size() > 0) begin
            m_host = 1'b0; m_rw = 1'b0; {m_a, m_d} = m_q[0]; m_phase = 1; m_starve = 0;
          end
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else begin
          m_phase = 0;
          if (m_host) begin
            m_done = 1'b1;
            if (m_rw) m_rdata = pk_din;
          end else begin
            m_pop = 1'b1;
          end
        end
        if (m_q.size() == 0) m_starve = 0;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back({p_addr, p_data});
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("busy",     32'(busy),       32'(m_phase != 0));
      chk("h_gnt",    32'(h_gnt),      32'(m_phase != 0 && m_host));
      chk("pk_cs",    32'(pk_cs),      (m_phase == 2) ? 32'd1 : 32'd2);
      chk("pk_rw",    32'(pk_rw),      (m_phase == 0) ? 32'd1 : 32'(m_rw));
      chk("pk_a",     32'(pk_a),       (m_phase == 0) ? 32'd0 : 32'(m_a));
      chk("pk_dout",  32'(pk_dout),    (m_phase == 0) ? 32'd0 : 32'(m_d));
      chk("h_done",   32'(h_done),     32'(m_done));
      chk("h_rdata",  32'(h_rdata),    32'(m_rdata));
      chk("level",    32'(fifo_level), 32'(m_q.size()));
      chk("p_ready",  32'(p_ready),    32'(m_q.size() < DEPTH));
    end
  end

  // Bus monitor: owner of each selected cycle and the player writes in bus order.
  logic [11:0] got_q[$];
  bit          own_q[$];
  always @(negedge clk) begin
    if (pk_cs == 2'b01) begin
      own_q.push_back(h_gnt);
      if (!h_gnt) got_q.push_back({pk_a, pk_dout});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_op(input logic rw, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] din, output logic rw_seen, output int ncyc);
    h_req = 1'b1; h_rw = rw; h_addr = a; h_wdata = d; pk_din = din;
    rw_seen = ~rw; ncyc = 0;
    while (ncyc < 64) begin
      tick; ncyc++;
      if (pk_cs == 2'b01) rw_seen = pk_rw;
      if (h_done) break;
    end
    chk("host_done_seen", 32'(h_done), 32'd1);
    h_req = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((fifo_level != '0 || busy) && n < 200) begin tick; n++; end
    chk("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  logic rw_seen, acc;
  int   ncyc, n, busy_c, cs_c, done_at;
  bit   exp_own[8];

  initial begin
    reset = 1'b1; en = 1'b1; h_req = 1'b0; h_rw = 1'b0; h_addr = 4'h0; h_wdata = 8'h00;
    p_valid = 1'b0; p_addr = 4'h0; p_data = 8'h00; pk_din = 8'h00;
    repeat (2) tick;
    chk("rst_pk_cs", 32'(pk_cs), 32'd2);
    chk("rst_pk_rw", 32'(pk_rw), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_p_ready", 32'(p_ready), 32'd1);
    chk("rst_h_rdata", 32'(h_rdata), 32'd0);
    reset = 1'b0;

    // Host write timing with en tied high.
    h_req = 1'b1; h_rw = 1'b0; h_addr = 4'h0; h_wdata = 8'hA5;
    tick;
    chk("wr_gnt_n", 32'(h_gnt), 32'd1);
    chk("wr_cs_addr", 32'(pk_cs), 32'd2);
    tick;
    chk("wr_cs_access", 32'(pk_cs), 32'd1);
    chk("wr_pk_a", 32'(pk_a), 32'd0);
    chk("wr_pk_dout", 32'(pk_dout), 32'hA5);
    chk("wr_pk_rw", 32'(pk_rw), 32'd0);
    chk("wr_no_done_yet", 32'(h_done), 32'd0);
    tick;
    chk("wr_done_clk3", 32'(h_done), 32'd1);
    chk("wr_cs_release", 32'(pk_cs), 32'd2);
    h_req = 1'b0;
    tick;
    chk("wr_done_pulse", 32'(h_done), 32'd0);

    // Host read.
    host_op(1'b1, 4'hA, 8'h00, 8'h3C, rw_seen, ncyc);
    chk("rd_rdata", 32'(h_rdata), 32'h3C);
    chk("rd_pk_rw", 32'(rw_seen), 32'd1);
    chk("rd_latency", 32'(ncyc), 32'd3);
    pk_din = 8'h55;
    repeat (2) tick;
    chk("rd_hold", 32'(h_rdata), 32'h3C);

    // FIFO fill, overflow, and bus order.
    en = 1'b0; got_q.delete();
    for (int i = 0; i < 8; i++) begin
      p_valid = 1'b1; p_addr = 4'(i); p_data = 8'(17 * i); tick;
    end
    chk("fill_level", 32'(fifo_level), 32'd8);
    chk("fill_p_ready", 32'(p_ready), 32'd0);
    p_addr = 4'h8; p_data = 8'h88;
    repeat (2) tick;
    chk("full_blocked", 32'(fifo_level), 32'd8);
    en = 1'b1; acc = 1'b0; n = 0;
    while (!acc && n < 64) begin acc = p_ready; tick; n++; end
    p_valid = 1'b0;
    chk("push9_accepted", 32'(acc), 32'd1);
    chk("push9_level", 32'(fifo_level), 32'd8);
    chk("push9_after_pop", 32'(got_q.size()), 32'd1);
    drain;
    chk("order_count", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      chk("order_entry", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFF, 32'({4'(i), 8'(17 * i)}));
    end

    // en strobe every fourth clock.
    busy_c = 0; cs_c = 0; done_at = -1;
    h_req = 1'b1; h_rw = 1'b0; h_addr = 4'h5; h_wdata = 8'h5A;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      en = (k % 4 == 0); tick;
      if (busy) busy_c++;
      if (pk_cs == 2'b01) cs_c++;
      if (h_done) done_at = k;
    end
    h_req = 1'b0; en = 1'b1;
    chk("slow_busy_clks", 32'(busy_c), 32'd8);
    chk("slow_access_clks", 32'(cs_c), 32'd4);
    chk("slow_done_strobe", 32'(done_at), 32'd8);

    // Continuous host request against a two-entry FIFO.
    en = 1'b0;
    p_valid = 1'b1; p_addr = 4'hC; p_data = 8'hC1; tick;
    p_addr = 4'hD; p_data = 8'hD2; tick;
    p_valid = 1'b0;
    own_q.delete();
    h_req = 1'b1; h_rw = 1'b0; h_addr = 4'h3; h_wdata = 8'h33; en = 1'b1;
    n = 0;
    while (own_q.size() < 8 && n < 100) begin tick; n++; end
    h_req = 1'b0;
`ifdef POKEY_ARB_STARVE_EN
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 8; i++) begin
      chk("starve_owner", (i < own_q.size()) ? 32'(own_q[i]) : 32'hF, 32'(exp_own[i]));
    end
    drain;

    // Reset in the middle of an access.
    en = 1'b0;
    p_valid = 1'b1; p_addr = 4'h9; p_data = 8'h99; tick;
    p_valid = 1'b0; en = 1'b1;
    h_req = 1'b1; h_rw = 1'b0; h_addr = 4'h7; h_wdata = 8'h77;
    n = 0;
    while (pk_cs != 2'b01 && n < 20) begin tick; n++; end
    chk("abort_reached_access", 32'(pk_cs), 32'd1);
    reset = 1'b1; tick;
    chk("abort_pk_cs", 32'(pk_cs), 32'd2);
    chk("abort_no_done", 32'(h_done), 32'd0);
    chk("abort_level", 32'(fifo_level), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0; h_req = 1'b0;
    tick;
    chk("abort_still_no_done", 32'(h_done), 32'd0);
    repeat (2) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

endmodule
